// File: rtl/hilo_unit.sv
// HI/LO register unit: MTHI/MTLO moves, single-cycle multiply and
// multiply-accumulate, and a 32-step restoring divider with sign fix-up.

package hilo_pkg;
    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MTHI  = 4'd1,
        OP_MTLO  = 4'd2,
        OP_MULT  = 4'd3,
        OP_MULTU = 4'd4,
        OP_MADD  = 4'd5,
        OP_MADDU = 4'd6,
        OP_MSUB  = 4'd7,
        OP_MSUBU = 4'd8,
        OP_DIV   = 4'd9,
        OP_DIVU  = 4'd10
    } op_t;
endpackage

// state | meaning
// IDLE  | ready for a request; MTHI/MTLO complete here
// MUL   | one cycle: product applied to {hi,lo} at the closing edge
// DIV   | 32 restoring iterations, one quotient bit per cycle
// FIX   | signs applied, lo=quotient, hi=remainder written at closing edge
module hilo_unit
    import hilo_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  req_valid,
    output logic  req_ready,
    input  op_t   op,
    input  word_t vs,
    input  word_t vt,
    input  logic  flush,
    output logic  busy,
    output logic  done,
    output word_t hi,
    output word_t lo
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    localparam logic [1:0] MODE_SET = 2'd0;
    localparam logic [1:0] MODE_ADD = 2'd1;
    localparam logic [1:0] MODE_SUB = 2'd2;

    state_t      state;
    word_t       a_q;          // multiplicand, or dividend shifting into quotient
    word_t       b_q;          // multiplier, or divisor magnitude
    word_t       rem_q;
    word_t       vs_q;         // original dividend, returned on divide by zero
    logic [4:0]  cnt_q;
    logic        mul_signed_q;
    logic [1:0]  mul_mode_q;
    logic        q_neg_q;
    logic        r_neg_q;
    logic        div_zero_q;

    logic        accept;
    logic        div_signed;
    word_t       vs_mag;
    word_t       vt_mag;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;
    logic [63:0] mul_res;
    logic [32:0] div_shift;
    logic [32:0] div_diff;

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign accept    = req_valid && req_ready && !flush;

    // done is gated by flush/reset so a cancelled final cycle never pulses
    assign done = (state == S_MUL || state == S_FIX) && !flush && !reset;

    // operand magnitudes for signed divide
    always_comb begin
        div_signed = (op == OP_DIV);
        vs_mag     = (div_signed && vs[31]) ? (~vs + 32'd1) : vs;
        vt_mag     = (div_signed && vt[31]) ? (~vt + 32'd1) : vt;
    end

    // 64-bit product (sign-extended operands give the signed product mod 2^64) and accumulate
    always_comb begin
        ext_a = {{32{mul_signed_q & a_q[31]}}, a_q};
        ext_b = {{32{mul_signed_q & b_q[31]}}, b_q};
        prod  = ext_a * ext_b;
        case (mul_mode_q)
            MODE_ADD: mul_res = {hi, lo} + prod;
            MODE_SUB: mul_res = {hi, lo} - prod;
            default:  mul_res = prod;
        endcase
    end

    // one restoring-division trial subtraction
    always_comb begin
        div_shift = {rem_q, a_q[31]};
        div_diff  = div_shift - {1'b0, b_q};
    end

    // control FSM and HI/LO datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            hi           <= '0;
            lo           <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rem_q        <= '0;
            vs_q         <= '0;
            cnt_q        <= '0;
            mul_signed_q <= 1'b0;
            mul_mode_q   <= MODE_SET;
            q_neg_q      <= 1'b0;
            r_neg_q      <= 1'b0;
            div_zero_q   <= 1'b0;
        end else if (state != S_IDLE && flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_MTHI: hi <= vs;
                            OP_MTLO: lo <= vs;
                            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                                a_q          <= vs;
                                b_q          <= vt;
                                mul_signed_q <= (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
                                if (op == OP_MADD || op == OP_MADDU)
                                    mul_mode_q <= MODE_ADD;
                                else if (op == OP_MSUB || op == OP_MSUBU)
                                    mul_mode_q <= MODE_SUB;
                                else
                                    mul_mode_q <= MODE_SET;
                                state <= S_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                a_q        <= vs_mag;
                                b_q        <= vt_mag;
                                rem_q      <= '0;
                                vs_q       <= vs;
                                cnt_q      <= 5'd31;
                                q_neg_q    <= div_signed && (vs[31] ^ vt[31]);
                                r_neg_q    <= div_signed && vs[31];
                                div_zero_q <= (vt == '0);
                                state      <= S_DIV;
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    {hi, lo} <= mul_res;
                    state    <= S_IDLE;
                end
                S_DIV: begin
                    if (!div_diff[32]) begin
                        rem_q <= div_diff[31:0];
                        a_q   <= {a_q[30:0], 1'b1};
                    end else begin
                        rem_q <= div_shift[31:0];
                        a_q   <= {a_q[30:0], 1'b0};
                    end
                    if (cnt_q == 5'd0)
                        state <= S_FIX;
                    else
                        cnt_q <= cnt_q - 5'd1;
                end
                S_FIX: begin
                    if (div_zero_q) begin
                        lo <= 32'hFFFF_FFFF;
                        hi <= vs_q;
                    end else begin
                        lo <= q_neg_q ? (~a_q + 32'd1) : a_q;
                        hi <= r_neg_q ? (~rem_q + 32'd1) : rem_q;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: directed vector table, flush/reset
// sequences, then random operations against an arithmetic reference model.
module tb_hilo_unit;
    import hilo_pkg::*;

    logic  clk = 1'b0;
    logic  reset;
    logic  req_valid;
    logic  req_ready;
    op_t   op;
    word_t vs;
    word_t vt;
    logic  flush;
    logic  busy;
    logic  done;
    word_t hi;
    word_t lo;

    always #5 clk = ~clk;

    hilo_unit dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .op        (op),
        .vs        (vs),
        .vt        (vt),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    int    checks   = 0;
    int    failures = 0;
    word_t m_hi     = '0;
    word_t m_lo     = '0;

    typedef struct {
        op_t   o;
        word_t a;
        word_t b;
        word_t e_hi;
        word_t e_lo;
        int    lat;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // busy cycles an operation should take, from the op class alone
    function automatic int lat_of(input op_t o);
        case (o)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1;
            OP_DIV, OP_DIVU: return 33;
            default: return 0;
        endcase
    endfunction

    // architectural result of one op, in plain arithmetic
    function automatic void model(input op_t o, input word_t a, input word_t b);
        longint      sa, sb, q, r;
        logic [63:0] acc, p;
        bit          sgn;
        sgn = (o == OP_MULT) || (o == OP_MADD) || (o == OP_MSUB) || (o == OP_DIV);
        sa  = sgn ? longint'($signed(a)) : longint'({32'b0, a});
        sb  = sgn ? longint'($signed(b)) : longint'({32'b0, b});
        p   = 64'(sa * sb);
        acc = {m_hi, m_lo};
        case (o)
            OP_MTHI: m_hi = a;
            OP_MTLO: m_lo = a;
            OP_MULT, OP_MULTU: {m_hi, m_lo} = p;
            OP_MADD, OP_MADDU: {m_hi, m_lo} = acc + p;
            OP_MSUB, OP_MSUBU: {m_hi, m_lo} = acc - p;
            OP_DIV, OP_DIVU: begin
                if (b == '0) begin
                    m_hi = a;
                    m_lo = 32'hFFFF_FFFF;
                end else begin
                    q    = sa / sb;
                    r    = sa % sb;
                    m_lo = word_t'(q);
                    m_hi = word_t'(r);
                end
            end
            default: ;
        endcase
    endfunction

    function automatic word_t pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return word_t'($urandom_range(0, 20));
            default: return word_t'($urandom);
        endcase
    endfunction

    // issue one op from IDLE and check its timing and final HI/LO
    task automatic exec(input string name, input op_t o, input word_t a, input word_t b,
                        input word_t e_hi, input word_t e_lo, input int e_lat);
        word_t h0, l0;
        int    nb, nd, dc;
        bit    stable;
        h0 = hi;
        l0 = lo;
        chk({name, "_ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        op        = o;
        vs        = a;
        vt        = b;
        tick();
        req_valid = 1'b0;
        op        = OP_NOP;
        vs        = word_t'($urandom);
        vt        = word_t'($urandom);
        nb        = 0;
        nd        = 0;
        dc        = 0;
        stable    = 1'b1;
        while (busy && nb < 40) begin
            nb++;
            if (done) begin
                nd++;
                dc = nb;
            end
            if (hi !== h0 || lo !== l0) stable = 1'b0;
            tick();
        end
        chk({name, "_busy_cycles"}, 64'(nb), 64'(e_lat));
        chk({name, "_done_count"}, 64'(nd), 64'(e_lat > 0));
        if (e_lat > 0) begin
            chk({name, "_done_cycle"}, 64'(dc), 64'(e_lat));
            chk({name, "_hilo_stable"}, 64'(stable), 64'd1);
        end
        chk({name, "_hi"}, 64'(hi), 64'(e_hi));
        chk({name, "_lo"}, 64'(lo), 64'(e_lo));
    endtask

    // issue an op, hold a second request during busy, flush in cycle fc
    task automatic flush_op(input string name, input op_t o, input word_t a, input word_t b, input int fc);
        word_t h0, l0;
        h0 = hi;
        l0 = lo;
        req_valid = 1'b1;
        op        = o;
        vs        = a;
        vt        = b;
        tick();
        op = OP_MTHI;
        vs = 32'h5555_5555;
        for (int c = 1; c < fc; c++) tick();
        chk({name, "_busy_before"}, 64'(busy), 64'd1);
        flush     = 1'b1;
        req_valid = 1'b0;
        #1;
        chk({name, "_done_suppressed"}, 64'(done), 64'd0);
        tick();
        flush = 1'b0;
        chk({name, "_idle_after"}, 64'(busy), 64'd0);
        chk({name, "_ready_after"}, 64'(req_ready), 64'd1);
        chk({name, "_hi_kept"}, 64'(hi), 64'(h0));
        chk({name, "_lo_kept"}, 64'(lo), 64'(l0));
    endtask

    initial begin
        op_t   ro;
        word_t ra, rb;

        tbl[0]  = '{OP_MULT,  32'hFFFF_FFFD, 32'h5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1};
        tbl[1]  = '{OP_MTHI,  32'h0,         32'h9,         32'h0,         32'hFFFF_FFF1, 0};
        tbl[2]  = '{OP_MTLO,  32'hFFFF_FFFF, 32'h9,         32'h0,         32'hFFFF_FFFF, 0};
        tbl[3]  = '{OP_MADDU, 32'h1,         32'h1,         32'h1,         32'h0,         1};
        tbl[4]  = '{OP_MSUB,  32'h1,         32'h1,         32'h0,         32'hFFFF_FFFF, 1};
        tbl[5]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
        tbl[6]  = '{OP_DIVU,  32'h8000_0000, 32'h0,         32'h8000_0000, 32'hFFFF_FFFF, 33};
        tbl[7]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 33};
        tbl[8]  = '{op_t'(4'd15), 32'h1,     32'h2,         32'h0,         32'h8000_0000, 0};
        tbl[9]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 33};
        tbl[10] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1};
        tbl[11] = '{OP_MADD,  32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1};
        tbl[12] = '{OP_MSUBU, 32'h2,         32'h3,         32'hFFFF_FFFD, 32'hFFFF_FFF9, 1};
        tbl[13] = '{OP_DIVU,  32'd100,       32'd7,         32'h2,         32'hE,         33};

        reset     = 1'b1;
        req_valid = 1'b0;
        flush     = 1'b0;
        op        = OP_NOP;
        vs        = '0;
        vt        = '0;
        repeat (2) tick();
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd1);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 14; i++)
            exec($sformatf("vec%0d", i), tbl[i].o, tbl[i].a, tbl[i].b,
                 tbl[i].e_hi, tbl[i].e_lo, tbl[i].lat);
        m_hi = hi;
        m_lo = lo;

        exec("mtlo_1234", OP_MTLO, 32'h1234, 32'h0, m_hi, 32'h1234, 0);
        m_lo = 32'h1234;
        flush_op("flush_div_c10", OP_DIVU, 32'd100, 32'd7, 10);
        flush_op("flush_div_fix", OP_DIV, 32'hFFFF_FFF9, 32'h2, 33);
        flush_op("flush_mul", OP_MADD, 32'd3, 32'd4, 1);
        exec("post_flush_divu", OP_DIVU, 32'd100, 32'd7, 32'h2, 32'hE, 33);

        exec("pre_rst_mthi", OP_MTHI, 32'hCAFE, 32'h0, 32'hCAFE, 32'hE, 0);
        req_valid = 1'b1;
        op        = OP_DIV;
        vs        = 32'd1000;
        vt        = 32'd3;
        tick();
        req_valid = 1'b0;
        repeat (4) tick();
        reset     = 1'b1;
        flush     = 1'b1;
        req_valid = 1'b1;
        op        = OP_MTHI;
        vs        = 32'h77;
        tick();
        reset     = 1'b0;
        flush     = 1'b0;
        req_valid = 1'b0;
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        flush     = 1'b1;
        op        = OP_MTHI;
        vs        = 32'hABCD;
        tick();
        op = OP_MTLO;
        tick();
        req_valid = 1'b0;
        flush     = 1'b0;
        chk("flushed_mthi_hi", 64'(hi), 64'd0);
        chk("flushed_mtlo_lo", 64'(lo), 64'd0);
        m_hi = '0;
        m_lo = '0;

        for (int i = 0; i < 40; i++) begin
            ro = op_t'($urandom_range(0, 15));
            ra = pick();
            rb = pick();
            model(ro, ra, rb);
            exec($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb, m_hi, m_lo, lat_of(ro));
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hilo_unit.md
HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous active-high reset.
REQ-003 SHALL have port: req_valid  input  1  HI/LO operation request.
REQ-004 SHALL have port: req_ready  output  1  high iff state IDLE; request accepted on req_valid & req_ready & ~flush.
REQ-005 SHALL have port: op  input  op_t  one of MTHI, MTLO, MULT, MULTU, MADD, MADDU, MSUB, MSUBU, DIV, DIVU; any other op = no-op.
REQ-006 SHALL have ports: vs, vt  input  word_t  rs and rt operand values.
REQ-007 SHALL have port: flush  input  1  cancels any in-flight or same-cycle request.
REQ-008 SHALL have port: busy  output  1  high in every non-IDLE state.
REQ-009 SHALL have port: done  output  1  one-cycle pulse in the final busy cycle of a MUL-class or DIV-class op.
REQ-010 SHALL have ports: hi, lo  output  word_t  architectural HI and LO register contents.

Function
REQ-011 SHALL implement states IDLE, MUL, DIV, FIX; acceptance cycle = cycle 0.
REQ-012 MTHI SHALL write hi=vs at the cycle-0 edge (lo unchanged), visible cycle 1; state stays IDLE, no busy, no done.
REQ-013 MTLO SHALL write lo=vs likewise (hi unchanged).
REQ-014 MUL-class ops SHALL latch operands at cycle 0, enter MUL for exactly one cycle (busy=1, done=1 in cycle 1), and update {hi,lo} at the end of cycle 1, visible cycle 2.
REQ-015 MULT/MADD/MSUB SHALL form the 64-bit signed product; MULTU/MADDU/MSUBU the unsigned product.
REQ-016 MULT/MULTU SHALL set {hi,lo}=product; MADD(U) SHALL set {hi,lo}={hi,lo}+product; MSUB(U) SHALL set {hi,lo}={hi,lo}-product; all modulo 2^64.
REQ-017 DIV-class ops SHALL latch operand magnitudes and sign flags at cycle 0, run 32 radix-2 restoring iterations in DIV (cycles 1..32, one quotient bit per cycle), then FIX for one cycle (cycle 33, done=1).
REQ-018 FIX SHALL apply signs (DIV only: quotient negated iff vs and vt signs differ; remainder takes the sign of vs) and write lo=quotient, hi=remainder, visible cycle 34.
REQ-019 Divide by zero SHALL take the same 34-cycle path and produce lo=32'hFFFF_FFFF, hi=vs (unsigned and signed alike).
REQ-020 DIV 32'h8000_0000 / 32'hFFFF_FFFF SHALL produce lo=32'h8000_0000, hi=0.
REQ-021 hi/lo SHALL NOT change in any cycle other than those specified in REQ-012 to REQ-019.
REQ-022 req_valid while busy SHALL be ignored; the requester holds it.
REQ-023 flush high in a non-IDLE state SHALL return the unit to IDLE at the next edge, with hi/lo unchanged and no done pulse in that cycle.
REQ-024 flush with req_valid in IDLE SHALL drop the request, including MTHI/MTLO.
REQ-025 On FIX or MUL exit, req_ready SHALL rise the cycle after done; no back-to-back overlap.

Reset
REQ-026 reset SHALL force state IDLE, hi=0, lo=0, busy=0, done=0, req_ready=1 at the next edge, overriding flush and req_valid.
REQ-027 reset asserted mid-MUL or mid-DIV SHALL abort the operation with no hi/lo write other than the zeroing in REQ-026.

Verification
REQ-028 MULT vs=32'hFFFF_FFFD (-3), vt=5 -> busy cycle 1 only, done cycle 1, cycle 2: hi=32'hFFFF_FFFF, lo=32'hFFFF_FFF1.
REQ-029 From hi=0, lo=32'hFFFF_FFFF: MADDU vs=1, vt=1 -> hi=1, lo=0; then MSUB vs=1, vt=1 -> hi=0, lo=32'hFFFF_FFFF.
REQ-030 DIV vs=32'hFFFF_FFF9 (-7), vt=2 -> busy cycles 1..33, done cycle 33 only, cycle 34: lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF.
REQ-031 DIVU vs=32'h8000_0000, vt=0 -> lo=32'hFFFF_FFFF, hi=32'h8000_0000 after 34 cycles; DIV 32'h8000_0000 / 32'hFFFF_FFFF -> lo=32'h8000_0000, hi=0.
REQ-032 MTLO 32'h1234 then DIVU 100/7 with flush at cycle 10 -> IDLE at cycle 11, no done pulse, lo=32'h1234 retained; a second req_valid during busy is not accepted.
REQ-033 reset at cycle 5 of a DIV -> cycle 6: hi=0, lo=0, busy=0, req_ready=1; MTHI with flush in the same cycle -> hi unchanged.
